rs_tx_mii: RTL and testbench

Transmit half of the reconciliation sublayer. It takes serial PLS_DATA.request bits from the MAC, packs them LSB-first into MII nibbles, and drives txd/tx_en/tx_er on a TX_CLK-rate nibble strobe. It enforces the inter-frame gap and flags underrun and odd-length frames. It pairs with the receive-side collision/PLS_SIGNAL.indication mapping in the same sublayer.

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_tx_nibble_asm.sv | 98 +++++++++
 rtl/rs_tx_mii.sv | 165 ++++++++++++++++
 tb/tb_rs_tx_mii.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the reconciliation sublayer transmit path:
// FSM state encoding, nibble width, default inter-frame gap and nibble padding helper.
package rs_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int IFG_NIBBLES_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XMIT  = 2'd1,
    DRAIN = 2'd2,
    IFG   = 2'd3
  } rs_state_e;

  // Keep the low 'cnt' bits of a nibble and force the rest to zero.
  function automatic logic [NIBBLE_W-1:0] pad_nibble(input logic [NIBBLE_W-1:0] nib,
                                                     input logic [1:0]          cnt);
    logic [NIBBLE_W-1:0] mask;
    mask = (4'd1 << cnt) - 4'd1;
    return nib & mask;
  endfunction

endpackage

// File: rtl/rs_tx_nibble_asm.sv
// Serial-to-nibble assembly for the MII transmit path: packs bits LSB-first,
// stages full nibbles in a hold register and turns an odd-length tail into an error nibble.
module rs_tx_nibble_asm
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                bit_acc,
  input  logic                bit_val,
  input  logic                complete_acc,
  input  logic                consume,
  output logic [NIBBLE_W-1:0] hold,
  output logic                hold_valid,
  output logic                hold_err,
  output logic                pending,
  output logic [1:0]          bit_cnt
);

  logic [NIBBLE_W-1:0] asm_r, asm_s, asm_n, hold_r, hold_n;
  logic [1:0]          bit_cnt_r, bit_cnt_n;
  logic                hold_valid_r, hold_valid_n, hold_err_r, hold_err_n;
  logic                pending_r, pending_n;
  logic [2:0]          new_cnt_s;
  logic                hold_free_s;

  // Next-state for assembly, hold and pending; a refill of hold beats its consumption.
  always_comb begin
    asm_s = asm_r;
    if (bit_acc) begin
      asm_s[bit_cnt_r] = bit_val;
    end else begin
      asm_s = asm_r;
    end
    new_cnt_s   = {1'b0, bit_cnt_r} + {2'b00, bit_acc};
    hold_free_s = !hold_valid_r || consume;

    asm_n        = asm_s;
    bit_cnt_n    = new_cnt_s[1:0];
    hold_n       = hold_r;
    hold_valid_n = hold_valid_r && !consume;
    hold_err_n   = hold_err_r;
    pending_n    = pending_r;

    if (new_cnt_s == 3'd4) begin
      hold_n       = asm_s;
      hold_valid_n = 1'b1;
      hold_err_n   = 1'b0;
      asm_n        = 4'd0;
      bit_cnt_n    = 2'd0;
    end else if (complete_acc && (new_cnt_s != 3'd0)) begin
      bit_cnt_n = 2'd0;
      if (hold_free_s) begin
        hold_n       = pad_nibble(asm_s, new_cnt_s[1:0]);
        hold_valid_n = 1'b1;
        hold_err_n   = 1'b1;
        asm_n        = 4'd0;
      end else begin
        // Residual parks in asm until the hold register drains.
        asm_n     = pad_nibble(asm_s, new_cnt_s[1:0]);
        pending_n = 1'b1;
      end
    end else if (pending_r && hold_free_s) begin
      hold_n       = asm_r;
      hold_valid_n = 1'b1;
      hold_err_n   = 1'b1;
      asm_n        = 4'd0;
      pending_n    = 1'b0;
    end else begin
      pending_n = pending_r;
    end
  end

  // Assembly and hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_r        <= 4'd0;
      bit_cnt_r    <= 2'd0;
      hold_r       <= 4'd0;
      hold_valid_r <= 1'b0;
      hold_err_r   <= 1'b0;
      pending_r    <= 1'b0;
    end else begin
      asm_r        <= asm_n;
      bit_cnt_r    <= bit_cnt_n;
      hold_r       <= hold_n;
      hold_valid_r <= hold_valid_n;
      hold_err_r   <= hold_err_n;
      pending_r    <= pending_n;
    end
  end

  assign hold       = hold_r;
  assign hold_valid = hold_valid_r;
  assign hold_err   = hold_err_r;
  assign pending    = pending_r;
  assign bit_cnt    = bit_cnt_r;

endmodule

// File: rtl/rs_tx_mii.sv
// Reconciliation sublayer transmit: PLS_DATA.request bits to MII txd/tx_en/tx_er
// with inter-frame gap enforcement and a saturating underrun counter.
module rs_tx_mii
  import rs_pkg::*;
#(
  parameter int IFG_NIBBLES = IFG_NIBBLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nibble_stb,
  input  logic                pls_data_req,
  input  logic                pls_data_bit,
  input  logic                pls_data_complete,
  output logic                pls_data_ready,
  output logic [NIBBLE_W-1:0] txd,
  output logic                tx_en,
  output logic                tx_er,
  output logic [CNT_W-1:0]    underrun_cnt
);

  localparam int              IFG_W    = (IFG_NIBBLES > 2) ? $clog2(IFG_NIBBLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_NIBBLES - 1);

  rs_state_e           state_r, state_n;
  logic [IFG_W-1:0]    ifg_cnt_r, ifg_cnt_n;
  logic [NIBBLE_W-1:0] txd_r, txd_n;
  logic                tx_en_r, tx_en_n, tx_er_r, tx_er_n;
  logic [CNT_W-1:0]    cnt_r, cnt_n, cnt_inc_s;

  logic [NIBBLE_W-1:0] hold_s;
  logic                hold_valid_s, hold_err_s, pending_s;
  logic [1:0]          bit_cnt_s;
  logic                ready_s, bit_acc_s, complete_acc_s, consume_s;

  assign ready_s        = !((hold_valid_s && (bit_cnt_s == 2'd3)) || (state_r == DRAIN) || (state_r == IFG));
  assign bit_acc_s      = pls_data_req && ready_s;
  // A complete with no bits behind it (IDLE, no coinciding bit) is dropped.
  assign complete_acc_s = pls_data_complete && ready_s && ((state_r == XMIT) || bit_acc_s);
  assign consume_s      = nibble_stb && hold_valid_s && ((state_r == XMIT) || (state_r == DRAIN));
  assign cnt_inc_s      = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);

  rs_tx_nibble_asm u_asm (
    .clk          (clk),
    .reset        (reset),
    .bit_acc      (bit_acc_s),
    .bit_val      (pls_data_bit),
    .complete_acc (complete_acc_s),
    .consume      (consume_s),
    .hold         (hold_s),
    .hold_valid   (hold_valid_s),
    .hold_err     (hold_err_s),
    .pending      (pending_s),
    .bit_cnt      (bit_cnt_s)
  );

  // Transmit FSM: next state, next output nibble, IFG and underrun counters.
  always_comb begin
    state_n   = state_r;
    ifg_cnt_n = ifg_cnt_r;
    txd_n     = txd_r;
    tx_en_n   = tx_en_r;
    tx_er_n   = tx_er_r;
    cnt_n     = cnt_r;
    case (state_r)
      IDLE: begin
        if (nibble_stb) begin
          txd_n   = 4'd0;
          tx_en_n = 1'b0;
          tx_er_n = 1'b0;
        end else begin
          txd_n = txd_r;
        end
        if (complete_acc_s) begin
          state_n = DRAIN;
        end else if (bit_acc_s) begin
          state_n = XMIT;
        end else begin
          state_n = IDLE;
        end
      end
      XMIT: begin
        if (nibble_stb && hold_valid_s) begin
          txd_n   = hold_s;
          tx_en_n = 1'b1;
          tx_er_n = hold_err_s;
        end else if (nibble_stb && tx_en_r) begin
          txd_n   = 4'd0;
          tx_en_n = 1'b1;
          tx_er_n = 1'b1;
          cnt_n   = cnt_inc_s;
        end else begin
          txd_n = txd_r;
        end
        if (complete_acc_s) begin
          state_n = DRAIN;
        end else begin
          state_n = XMIT;
        end
      end
      DRAIN: begin
        if (nibble_stb && hold_valid_s) begin
          txd_n   = hold_s;
          tx_en_n = 1'b1;
          tx_er_n = hold_err_s;
        end else if (nibble_stb && pending_s) begin
          txd_n   = 4'd0;
          tx_en_n = 1'b1;
          tx_er_n = 1'b1;
        end else if (nibble_stb) begin
          txd_n     = 4'd0;
          tx_en_n   = 1'b0;
          tx_er_n   = 1'b0;
          ifg_cnt_n = IFG_LOAD;
          state_n   = IFG;
        end else begin
          state_n = DRAIN;
        end
      end
      IFG: begin
        if (nibble_stb) begin
          txd_n   = 4'd0;
          tx_en_n = 1'b0;
          tx_er_n = 1'b0;
          if (ifg_cnt_r == '0) begin
            state_n = IDLE;
          end else begin
            ifg_cnt_n = ifg_cnt_r - IFG_W'(1);
          end
        end else begin
          state_n = IFG;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      ifg_cnt_r <= '0;
      txd_r     <= 4'd0;
      tx_en_r   <= 1'b0;
      tx_er_r   <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_n;
      ifg_cnt_r <= ifg_cnt_n;
      txd_r     <= txd_n;
      tx_en_r   <= tx_en_n;
      tx_er_r   <= tx_er_n;
      cnt_r     <= cnt_n;
    end
  end

  assign pls_data_ready = ready_s;
  assign txd            = txd_r;
  assign tx_en          = tx_en_r;
  assign tx_er          = tx_er_r;
  assign underrun_cnt   = cnt_r;

endmodule

// File: tb/tb_rs_tx_mii.sv
// Directed and randomized bench for rs_tx_mii: a nibble scoreboard built from the
// frame's bit list, an underrun tally and an IFG strobe count judge the outputs.
module tb_rs_tx_mii;

  logic       clk = 1'b0;
  logic       reset, nibble_stb, pls_data_req, pls_data_bit, pls_data_complete;
  logic       pls_data_ready, tx_en, tx_er;
  logic [3:0] txd;
  logic [7:0] underrun_cnt;

  int vectors = 0, miscompares = 0;
  int period = 4, cyc = 0;
  logic [4:0] exp_q[$];
  bit fq[$];
  int under_model = 0, nibbles_seen = 0, ifg_strobes = 0;
  bit prev_en = 1'b0, in_ifg = 1'b0, frame_fell = 1'b0;
  bit saw_ready_low = 1'b0, ready_low_bits = 1'b0;
  bit last_bit_acc, last_cpl_acc;

  always #5 clk = ~clk;

  rs_tx_mii #(.IFG_NIBBLES(24), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .nibble_stb(nibble_stb),
    .pls_data_req(pls_data_req), .pls_data_bit(pls_data_bit),
    .pls_data_complete(pls_data_complete), .pls_data_ready(pls_data_ready),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .underrun_cnt(underrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // One clock: apply strobe, clock, then judge outputs 1 time unit after the edge.
  task automatic step();
    logic [5:0] pre;
    logic       rdy_pre, stb;
    logic [4:0] e;
    stb = ((cyc % period) == 0);
    cyc++;
    nibble_stb = stb;
    rdy_pre = pls_data_ready;
    pre = {tx_en, tx_er, txd};
    @(posedge clk);
    #1;
    last_bit_acc = pls_data_req && rdy_pre;
    last_cpl_acc = pls_data_complete && rdy_pre;
    if (!rdy_pre) saw_ready_low = 1'b1;
    if (!stb) begin
      check("stable_outputs", {26'd0, tx_en, tx_er, txd}, {26'd0, pre});
    end else begin
      if (tx_en) begin
        if (tx_er && (txd == 4'h0)) begin
          under_model++;
        end else begin
          check("nibble_available", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_nibble", {tx_er, txd}, e);
            nibbles_seen++;
          end
        end
      end else if (prev_en) begin
        check("drain_empty", exp_q.size(), 0);
        check("idle_out", {tx_er, txd}, 5'h00);
        in_ifg = 1'b1;
        ifg_strobes = 0;
        frame_fell = 1'b1;
      end else if (in_ifg) begin
        ifg_strobes++;
      end
      check("underrun_cnt", underrun_cnt, sat255(under_model));
      prev_en = tx_en;
    end
    if (in_ifg && pls_data_ready) begin
      check("ifg_strobes", ifg_strobes, 24);
      in_ifg = 1'b0;
    end
  endtask

  task automatic load_bits(input logic [31:0] v, input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(v[i]);
  endtask

  task automatic do_reset_abort();
    check("abort_midframe_en", tx_en, 1'b1);
    pls_data_req = 1'b0;
    pls_data_complete = 1'b0;
    nibble_stb = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_outputs", {tx_en, tx_er, txd}, 6'h00);
    check("abort_cnt", underrun_cnt, 8'h00);
    check("abort_ready", pls_data_ready, 1'b1);
    exp_q.delete();
    under_model = 0;
    prev_en = 1'b0;
    in_ifg = 1'b0;
    frame_fell = 1'b1;
    #1 reset = 1'b0;
  endtask

  // Drive the bits in fq as one frame; expected nibbles come from plain LSB-first packing.
  task automatic send_frame(input int gap_pct, input int stall_idx, input int stall_cyc,
                            input bit cpl_last, input int abort_nib);
    int n, idx, guard, sidx;
    bit done_cpl;
    logic [4:0] e;
    n = fq.size();
    for (int i = 0; i < n; i += 4) begin
      e = 5'd0;
      for (int j = 0; j < 4; j++) if (i + j < n) e[j] = fq[i+j];
      e[4] = ((n - i) < 4);
      exp_q.push_back(e);
    end
    nibbles_seen = 0; frame_fell = 1'b0; saw_ready_low = 1'b0;
    idx = 0; guard = 0; done_cpl = 1'b0; sidx = stall_idx;
    while (idx < n && guard < 4000) begin
      guard++;
      if (idx == sidx) begin
        pls_data_req = 1'b0;
        pls_data_complete = 1'b0;
        for (int k = 0; k < 400 && nibbles_seen == 0; k++) step();
        for (int k = 0; k < stall_cyc; k++) step();
        sidx = -1;
      end
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        pls_data_req = 1'b0;
        pls_data_complete = 1'b0;
        step();
      end else begin
        pls_data_req = 1'b1;
        pls_data_bit = fq[idx];
        pls_data_complete = cpl_last && (idx == n - 1);
        step();
        if (last_bit_acc) begin
          idx++;
          done_cpl = last_cpl_acc;
        end
      end
      if (abort_nib > 0 && nibbles_seen >= abort_nib) begin
        do_reset_abort();
        return;
      end
    end
    ready_low_bits = saw_ready_low;
    pls_data_req = 1'b0;
    while (!done_cpl && guard < 4000) begin
      guard++;
      pls_data_complete = 1'b1;
      step();
      done_cpl = last_cpl_acc;
    end
    pls_data_complete = 1'b0;
    while (!frame_fell && guard < 4000) begin
      guard++;
      step();
    end
    check("frame_completes", frame_fell, 1'b1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    pls_data_req = 1'b0;
    pls_data_complete = 1'b0;
    while ((in_ifg || tx_en) && g < 2000) begin
      g++;
      step();
    end
    check("idle_reached", {in_ifg, tx_en}, 2'b00);
  endtask

  initial begin
    int base, len, rem;
    bit any1;
    reset = 1'b1; nibble_stb = 1'b0; pls_data_req = 1'b0;
    pls_data_bit = 1'b0; pls_data_complete = 1'b0;
    #1;
    check("reset_outputs", {tx_en, tx_er, txd}, 6'h00);
    check("reset_cnt", underrun_cnt, 8'h00);
    check("reset_ready", pls_data_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1,0,1,0,0,0,1,1 -> 0x5 then 0xC, then a 24-strobe gap.
    load_bits(32'hC5, 8);
    send_frame(0, -1, 0, 1'b0, 0);
    check("frame1_no_underrun", underrun_cnt, 8'd0);
    wait_idle();

    // 1,1,1,1,1,0 -> 0xF clean, then 0x1 flagged.
    load_bits(32'h1F, 6);
    send_frame(0, -1, 0, 1'b1, 0);
    wait_idle();

    // Lone complete in IDLE must not start a drain/IFG.
    pls_data_complete = 1'b1;
    step();
    pls_data_complete = 1'b0;
    repeat (8) step();
    check("idle_complete_ignored", {pls_data_ready, tx_en}, 2'b10);

    // 0xA then a stall spanning two strobes -> two underrun nibbles.
    base = under_model;
    load_bits(32'h3A, 8);
    send_frame(0, 4, 5, 1'b1, 0);
    check("stall_underruns", under_model - base, 2);
    check("stall_underrun_cnt", underrun_cnt, 8'd2);
    wait_idle();

    // Strobe every 8 clocks with bits every clock: backpressure must show.
    period = 8;
    load_bits($urandom, 16);
    send_frame(0, -1, 0, 1'b0, 0);
    check("ready_backpressure", ready_low_bits, 1'b1);
    wait_idle();

    // Long stall at a fast strobe drives the counter into saturation.
    period = 2;
    load_bits(32'h96, 8);
    send_frame(0, 4, 620, 1'b1, 0);
    check("underrun_saturated", underrun_cnt, 8'd255);
    wait_idle();

    // Reset after three nibbles, then a clean frame.
    period = 4;
    load_bits($urandom, 32);
    send_frame(0, -1, 0, 1'b0, 3);
    wait_idle();
    load_bits($urandom, 12);
    send_frame(0, -1, 0, 1'b1, 0);
    wait_idle();

    // Randomized frames; odd tails forced to contain a 1 so they never look like underruns.
    for (int f = 0; f < 6; f++) begin
      period = $urandom_range(8, 2);
      len = $urandom_range(40, 1);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(1'($urandom_range(1, 0)));
      rem = len % 4;
      if (rem != 0) begin
        any1 = 1'b0;
        for (int i = len - rem; i < len; i++) any1 = any1 | fq[i];
        if (!any1) fq[len-1] = 1'b1;
      end
      send_frame($urandom_range(50, 0), -1, 0, 1'($urandom_range(1, 0)), 0);
      if (f % 2 == 1) wait_idle();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
